display_frame_streamer: RTL and testbench

Sequential, parametrised successor to the combinational display datapath. It latches a garbler message, a watermark, z and an evaluator seed. It then generates NB_FRAMES successive frames, each with fresh LFSR-derived randomness, and streams each frame's pixels as fixed-width beats over a valid/ready interface. Segment-to-pixel mapping stays external: this block drives sel_seg into an external segment2pixel instance and samples its pix_segments result.

---
 rtl/display_frame_streamer.sv | 208 ++++++++++++++++++++
 tb/tb_display_frame_streamer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/display_frame_streamer.sv
// Streams NB_FRAMES watermarked, LFSR-randomised frames as PIX_PER_BEAT-wide valid/ready beats.
// Optional out_parity port (XOR of out_data) is enabled by defining DISPLAY_STREAM_PARITY_EN.
module display_frame_streamer #(
    parameter int WIDTH        = 120,
    parameter int HEIGHT       = 52,
    parameter int NB_SEGMENTS  = 28,
    parameter int RND_WIDTH    = 16,
    parameter int PIX_PER_BEAT = 8,
    parameter int NB_FRAMES    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      z,
    input  logic [NB_SEGMENTS-1:0]    msg,
    input  logic [WIDTH*HEIGHT-1:0]   watmk,
    input  logic [RND_WIDTH-1:0]      seed,
    output logic [NB_SEGMENTS-1:0]    sel_seg,
    input  logic [WIDTH*HEIGHT-1:0]   pix_segments,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIX_PER_BEAT-1:0]   out_data,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic                      out_last,
    output logic [7:0]                out_frame,
    output logic                      busy,
    output logic                      done
`ifdef DISPLAY_STREAM_PARITY_EN
    ,
    output logic                      out_parity
`endif
);
    localparam int NPIX     = WIDTH * HEIGHT;
    localparam int NB_BEATS = NPIX / PIX_PER_BEAT;
    localparam int BEAT_W   = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NB_BEATS - 1);
    localparam logic [7:0]        LAST_FRAME = 8'(NB_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STREAM} state_t;

    state_t                   state_q, state_d;
    logic [RND_WIDTH-1:0]     lfsr_q, lfsr_d;
    logic [NB_SEGMENTS-1:0]   msg_q, msg_d;
    logic                     z_q, z_d;
    logic [NPIX-1:0]          watmk_q, watmk_d;
    logic [NPIX-1:0]          fbuf_q, fbuf_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [NB_SEGMENTS-1:0]   sel_seg_q, sel_seg_d;
    logic                     out_valid_q, out_valid_d;
    logic [PIX_PER_BEAT-1:0]  out_data_q, out_data_d;
    logic                     out_sof_q, out_sof_d;
    logic                     out_eof_q, out_eof_d;
    logic                     out_last_q, out_last_d;
    logic [7:0]               out_frame_q, out_frame_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    function automatic logic [RND_WIDTH-1:0] lfsr_step(input logic [RND_WIDTH-1:0] s);
        return {s[RND_WIDTH-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Segment i is shown when z is set or its LFSR bit (wrapped modulo RND_WIDTH) is set.
    function automatic logic [NB_SEGMENTS-1:0] select_segs(
        input logic [NB_SEGMENTS-1:0] m,
        input logic                   zz,
        input logic [RND_WIDTH-1:0]   s
    );
        logic [NB_SEGMENTS-1:0] r;
        for (int i = 0; i < NB_SEGMENTS; i++) begin
            r[i] = s[i % RND_WIDTH];
        end
        return m & ({NB_SEGMENTS{zz}} | r);
    endfunction

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        msg_d       = msg_q;
        z_d         = z_q;
        watmk_d     = watmk_q;
        fbuf_d      = fbuf_q;
        beat_d      = beat_q;
        sel_seg_d   = sel_seg_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_last_d  = out_last_q;
        out_frame_d = out_frame_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    msg_d       = msg;
                    z_d         = z;
                    watmk_d     = watmk;
                    lfsr_d      = (seed == '0) ? RND_WIDTH'(1) : seed;
                    sel_seg_d   = select_segs(msg, z, lfsr_d);
                    out_frame_d = 8'd0;
                    busy_d      = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                // pix_segments has had a full cycle to settle from sel_seg_q.
                fbuf_d      = pix_segments ^ watmk_q;
                beat_d      = '0;
                out_valid_d = 1'b1;
                out_data_d  = fbuf_d[0 +: PIX_PER_BEAT];
                out_sof_d   = 1'b1;
                out_eof_d   = (NB_BEATS == 1);
                out_last_d  = out_eof_d && (out_frame_q == LAST_FRAME);
                state_d     = STREAM;
            end
            STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (out_eof_q) begin
                        out_valid_d = 1'b0;
                        out_sof_d   = 1'b0;
                        out_eof_d   = 1'b0;
                        out_last_d  = 1'b0;
                        if (out_frame_q == LAST_FRAME) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            lfsr_d      = lfsr_step(lfsr_q);
                            out_frame_d = out_frame_q + 8'd1;
                            sel_seg_d   = select_segs(msg_q, z_q, lfsr_d);
                            state_d     = SETUP;
                        end
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        out_data_d = fbuf_q[int'(beat_d) * PIX_PER_BEAT +: PIX_PER_BEAT];
                        out_sof_d  = 1'b0;
                        out_eof_d  = (beat_d == LAST_BEAT);
                        out_last_d = out_eof_d && (out_frame_q == LAST_FRAME);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= RND_WIDTH'(1);
            msg_q       <= '0;
            z_q         <= 1'b0;
            watmk_q     <= '0;
            fbuf_q      <= '0;
            beat_q      <= '0;
            sel_seg_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_frame_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            msg_q       <= msg_d;
            z_q         <= z_d;
            watmk_q     <= watmk_d;
            fbuf_q      <= fbuf_d;
            beat_q      <= beat_d;
            sel_seg_q   <= sel_seg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_last_q  <= out_last_d;
            out_frame_q <= out_frame_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef DISPLAY_STREAM_PARITY_EN
    logic out_parity_q;
    // Tracks out_data_d, so it follows the same load and hold timing as out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= ^out_data_d;
        end
    end
    assign out_parity = out_parity_q;
`endif

    assign sel_seg   = sel_seg_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_last  = out_last_q;
    assign out_frame = out_frame_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_display_frame_streamer.sv
// Table-driven bench for display_frame_streamer on a 4x2 frame, 4-pixel beats, 2 frames per run.
module tb_display_frame_streamer;
    localparam int W = 4, H = 2, P = 4, NS = 4, NF = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          z = 1'b0;
    logic [NS-1:0] msg = '0;
    logic [W*H-1:0] watmk = '0;
    logic [15:0]   seed = '0;
    logic [NS-1:0] sel_seg;
    logic [W*H-1:0] pix_segments;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [P-1:0]  out_data;
    logic          out_sof, out_eof, out_last;
    logic [7:0]    out_frame;
    logic          busy, done;
`ifdef DISPLAY_STREAM_PARITY_EN
    logic          out_parity;
`endif

    assign pix_segments = {sel_seg, sel_seg};

    display_frame_streamer #(
        .WIDTH(W), .HEIGHT(H), .NB_SEGMENTS(NS), .RND_WIDTH(16),
        .PIX_PER_BEAT(P), .NB_FRAMES(NF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .z(z), .msg(msg), .watmk(watmk),
        .seed(seed), .sel_seg(sel_seg), .pix_segments(pix_segments),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof), .out_last(out_last),
        .out_frame(out_frame), .busy(busy), .done(done)
`ifdef DISPLAY_STREAM_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        z;
        logic [3:0]  msg;
        logic [7:0]  watmk;
        logic [15:0] seed;
        logic [3:0]  sel0, sel1;   // expected sel_seg per frame
        logic [3:0]  d0, d1;       // expected beat data per frame
        int          stall;        // cycles of out_ready low on beat 1
        bit          abort;        // reset at frame1 beat0
        bit          poke;         // extra start pulse while busy
    } vec_t;

    vec_t vecs[8];

    task automatic do_run(input int n, input vec_t v);
        int         idx = 0;
        int         cyc = 0;
        int         stall_left = v.stall;
        int         bubbles = 0;
        bit         fin = 0;
        logic [3:0] exp_d;
        logic [3:0] exp_s;
        @(negedge clk);
        z = v.z; msg = v.msg; watmk = v.watmk; seed = v.seed;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs change after the start edge; the run must ignore them.
        z = ~z; msg = ~msg; watmk = ~watmk; seed = ~seed;
        check("busy_after_start", busy, 1);
        check("valid_in_setup", out_valid, 0);
        while (!fin && cyc < 40) begin
            @(posedge clk); cyc++; #1;
            start = (v.poke && cyc == 2);
            exp_d = (idx < 2) ? v.d0 : v.d1;
            exp_s = (idx < 2) ? v.sel0 : v.sel1;
            if (done) begin
                check("done_cycle", cyc, 6 + v.stall);
                check("beats_at_done", idx, 4);
                check("bubble_cycles", bubbles, 1);
                check("busy_at_done", busy, 0);
                check("valid_at_done", out_valid, 0);
                fin = 1;
                @(posedge clk); #1;
                check("done_pulse_width", done, 0);
            end else if (out_valid) begin
                if (v.abort && idx == 2) begin
                    rst = 1'b1; #1;
                    check("rst_valid", out_valid, 0);
                    check("rst_busy", busy, 0);
                    check("rst_sel_seg", sel_seg, 0);
                    check("rst_frame", out_frame, 0);
                    check("rst_sof", out_sof, 0);
                    @(negedge clk); rst = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        @(posedge clk); #1;
                        check("no_done_after_rst", done, 0);
                        check("idle_after_rst", out_valid, 0);
                    end
                    fin = 1;
                end else if (stall_left > 0 && idx == 1) begin
                    out_ready = 1'b0;
                    stall_left--;
                    check("hold_data", out_data, exp_d);
                    check("hold_eof", out_eof, 1);
                    check("hold_sof", out_sof, 0);
                    check("hold_frame", out_frame, 0);
                end else begin
                    out_ready = 1'b1;
                    check("beat_data", out_data, exp_d);
                    check("beat_sof", out_sof, (idx % 2 == 0));
                    check("beat_eof", out_eof, (idx % 2 == 1));
                    check("beat_last", out_last, (idx == 3));
                    check("beat_frame", out_frame, idx / 2);
                    check("beat_busy", busy, 1);
`ifdef DISPLAY_STREAM_PARITY_EN
                    check("beat_parity", out_parity, ^exp_d);
`endif
                    if (out_sof) check("frame_sel_seg", sel_seg, exp_s);
                    idx++;
                end
            end else begin
                if (idx == 2) bubbles++;
                out_ready = 1'b1;
            end
        end
        start = 1'b0;
        if (!fin) check("run_timeout", 0, 1);
        $display("run %0d: z=%0b msg=%0h watmk=%0h seed=%0h stall=%0d abort=%0b poke=%0b beats=%0d cycles=%0d",
                 n, v.z, v.msg, v.watmk, v.seed, v.stall, v.abort, v.poke, idx, cyc);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'hA, 8'h00, 16'h1234, 4'hA, 4'hA, 4'hA, 4'hA, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'hF, 8'h00, 16'h0000, 4'h1, 4'h2, 4'h1, 4'h2, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'hA, 8'hFF, 16'h1234, 4'hA, 4'hA, 4'h5, 4'h5, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'hA, 8'h00, 16'h1234, 4'hA, 4'hA, 4'hA, 4'hA, 5, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 4'hA, 8'h00, 16'h1234, 4'hA, 4'hA, 4'hA, 4'hA, 0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'hA, 8'h00, 16'h1234, 4'hA, 4'hA, 4'hA, 4'hA, 0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 4'hA, 8'h00, 16'h1234, 4'hA, 4'hA, 4'hA, 4'hA, 0, 1'b0, 1'b1};
        // LFSR 0x1234 -> 0x2469: low nibbles 4 then 9.
        vecs[7] = '{1'b0, 4'hF, 8'h00, 16'h1234, 4'h4, 4'h9, 4'h4, 4'h9, 0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_sof", out_sof, 0);
        check("reset_eof", out_eof, 0);
        check("reset_last", out_last, 0);
        check("reset_frame", out_frame, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sel_seg", sel_seg, 0);
`ifdef DISPLAY_STREAM_PARITY_EN
        check("reset_parity", out_parity, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_run(i, vecs[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
